bram_copy_engine: RTL and testbench

BRAM_COPY_ENGINE -- requirements
Module: bram_copy_engine

---
 rtl/bram_copy_pkg.sv | 11 +
 rtl/bram_copy_engine.sv | 93 +++++++++
 tb/tb_bram_copy_engine.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_copy_pkg.sv
// Shared types for the BRAM copy engine.
package bram_copy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/bram_copy_engine.sv
// Copies N words between two regions of a dual-port BRAM at one word per cycle:
// port A streams reads, port B writes the returned data one cycle later.
module bram_copy_engine
  import bram_copy_pkg::*;
#(
  parameter int P_DATA_WIDTH    = 16,
  parameter int P_ADDRESS_WIDTH = 10
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic                       I_START,
  input  logic [P_ADDRESS_WIDTH-1:0] I_SRC_ADDRESS,
  input  logic [P_ADDRESS_WIDTH-1:0] I_DST_ADDRESS,
  input  logic [P_ADDRESS_WIDTH:0]   I_LENGTH,
  output logic                       O_BUSY,
  output logic                       O_DONE,
  output logic [P_ADDRESS_WIDTH-1:0] O_ADDRESS_A,
  output logic                       O_WRITE_ENABLE_A,
  input  logic [P_DATA_WIDTH-1:0]    I_DATA_A,
  output logic [P_ADDRESS_WIDTH-1:0] O_ADDRESS_B,
  output logic [P_DATA_WIDTH-1:0]    O_DATA_B,
  output logic                       O_WRITE_ENABLE_B
);

  localparam int unsigned LW = P_ADDRESS_WIDTH + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {P_ADDRESS_WIDTH{1'b0}}};

  state_e                     state_q, state_d;
  logic [P_ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [P_ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [LW-1:0]              rd_cnt_q, rd_cnt_d;
  logic                       wr_en_q, wr_en_d;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_cnt_d  = rd_cnt_q;
    wr_en_d   = 1'b0;

    // Write side trails the read side by the BRAM's one-cycle read latency.
    if (wr_en_q) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (I_START) begin
          rd_addr_d = I_SRC_ADDRESS;
          wr_addr_d = I_DST_ADDRESS;
          rd_cnt_d  = (I_LENGTH > MAX_LEN) ? MAX_LEN : I_LENGTH;
          state_d   = (I_LENGTH == '0) ? DONE : READ;
        end
      end
      READ: begin
        rd_addr_d = rd_addr_q + 1'b1;
        rd_cnt_d  = rd_cnt_q - 1'b1;
        wr_en_d   = 1'b1;
        if (rd_cnt_q == LW'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_cnt_q  <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign O_BUSY           = (state_q == READ) || (state_q == DRAIN);
  assign O_DONE           = (state_q == DONE);
  assign O_ADDRESS_A      = rd_addr_q;
  assign O_WRITE_ENABLE_A = 1'b0;
  assign O_ADDRESS_B      = wr_addr_q;
  assign O_DATA_B         = I_DATA_A;
  assign O_WRITE_ENABLE_B = wr_en_q;

endmodule

// File: tb/tb_bram_copy_engine.sv
// Bench for bram_copy_engine: attached behavioural BRAM, timeline-based reference model,
// per-cycle output comparison and directed copy scenarios.
module tb_bram_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  src_a, dst_a;
  logic [10:0] len;
  logic        busy, done, we_a, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;

  always #5 clk = ~clk;

  bram_copy_engine #(.P_DATA_WIDTH(16), .P_ADDRESS_WIDTH(10)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_START(start),
    .I_SRC_ADDRESS(src_a), .I_DST_ADDRESS(dst_a), .I_LENGTH(len),
    .O_BUSY(busy), .O_DONE(done),
    .O_ADDRESS_A(addr_a), .O_WRITE_ENABLE_A(we_a), .I_DATA_A(data_a),
    .O_ADDRESS_B(addr_b), .O_DATA_B(data_b), .O_WRITE_ENABLE_B(we_b)
  );

  // Dual-port BRAM, registered read on A, write on B.
  logic [15:0] mem [1024];
  always @(posedge clk) begin
    if (we_b) mem[addr_b] <= data_b;
    data_a <= mem[addr_a];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: copy described as a timeline t = cycles since the accepting edge.
  logic [15:0] ref_mem [1024];
  int          snap [1024];
  bit          m_active = 0, m_rst_addr = 0, chk_en = 0;
  int          m_t, m_n, m_src, m_dst, m_done_t;

  always @(posedge clk) begin
    if (m_active && m_t >= 1 && m_t <= m_n)
      ref_mem[(m_dst + m_t - 1) % 1024] = 16'(snap[m_t - 1]);
    if (rst) begin
      m_active = 0; m_rst_addr = 1; chk_en = 1;
    end else if (m_active) begin
      m_t++;
      if (m_t > m_done_t) m_active = 0;
    end else if (start) begin
      m_active = 1; m_rst_addr = 0; m_t = 0;
      m_src = int'(src_a); m_dst = int'(dst_a);
      m_n = (int'(len) > 1024) ? 1024 : int'(len);
      m_done_t = (m_n == 0) ? 0 : m_n + 1;
      for (int i = 0; i < m_n; i++) snap[i] = int'(ref_mem[(m_src + i) % 1024]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we_a", 32'(we_a), 0);
      if (!m_active) begin
        chk("busy_idle", 32'(busy), 0);
        chk("done_idle", 32'(done), 0);
        chk("we_b_idle", 32'(we_b), 0);
        if (m_rst_addr) begin
          chk("addr_a_rst", 32'(addr_a), 0);
          chk("addr_b_rst", 32'(addr_b), 0);
        end
      end else begin
        chk("busy", 32'(busy), 32'(m_n > 0 && m_t <= m_n));
        chk("done", 32'(done), 32'(m_t == m_done_t));
        if (m_t < m_n) chk("addr_a", 32'(addr_a), 32'((m_src + m_t) % 1024));
        chk("we_b", 32'(we_b), 32'(m_t >= 1 && m_t <= m_n));
        if (m_t >= 1 && m_t <= m_n) begin
          chk("addr_b", 32'(addr_b), 32'((m_dst + m_t - 1) % 1024));
          chk("data_b", 32'(data_b), 32'(snap[m_t - 1]));
        end
      end
    end
  end

  // Activity monitor for hand-computed timing expectations.
  int cyc = 0, k_cyc = 0, busy_cnt = 0, done_cnt = 0, web_cnt = 0, done_t = -1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      busy_cnt += int'(busy);
      web_cnt  += int'(we_b);
      if (done) begin
        done_cnt++;
        done_t = cyc - k_cyc;
      end
    end
  end

  task automatic start_copy(input int s, input int d, input int n);
    @(negedge clk); #1;
    busy_cnt = 0; done_cnt = 0; web_cnt = 0; done_t = -1;
    k_cyc = cyc + 1;
    src_a = 10'(s); dst_a = 10'(d); len = 11'(n); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    src_a = 10'h3ff; dst_a = 10'h155; len = 11'd3;  // later changes must not matter
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt > 0 && !done) break;
    end
    if (i == limit) chk("timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic mem_check(input string nm);
    int diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk(nm, 32'(diffs), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'(i + 1);
      ref_mem[i] = 16'(i + 1);
    end
    rst = 1'b1; start = 1'b0; src_a = '0; dst_a = '0; len = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr_a", 32'(addr_a), 0);
    #1 rst = 1'b0;

    // Basic copy 0..7 -> 100..107
    start_copy(0, 100, 8);
    wait_done(40);
    for (int i = 0; i < 8; i++) chk("t1_mem", 32'(mem[100 + i]), 32'(i + 1));
    chk("t1_busy_cycles", 32'(busy_cnt), 9);
    chk("t1_done_t", 32'(done_t), 9);
    chk("t1_done_cnt", 32'(done_cnt), 1);
    mem_check("t1_memall");

    // Zero length
    start_copy(0, 100, 0);
    wait_done(10);
    chk("t2_done_t", 32'(done_t), 0);
    chk("t2_busy_cycles", 32'(busy_cnt), 0);
    chk("t2_writes", 32'(web_cnt), 0);
    mem_check("t2_memall");

    // Source wraps past the top of the address space
    start_copy(1020, 200, 8);
    wait_done(40);
    for (int i = 0; i < 4; i++) chk("t3_mem_hi", 32'(mem[200 + i]), 32'(1021 + i));
    for (int i = 4; i < 8; i++) chk("t3_mem_lo", 32'(mem[200 + i]), 32'(i - 3));
    mem_check("t3_memall");

    // Start pulse during a copy is ignored
    start_copy(8, 400, 8);
    repeat (2) @(negedge clk);
    #1 start = 1'b1; src_a = 10'd16; dst_a = 10'd500; len = 11'd4;
    @(negedge clk); #1 start = 1'b0;
    wait_done(40);
    for (int i = 0; i < 8; i++) chk("t4_mem", 32'(mem[400 + i]), 32'(9 + i));
    for (int i = 0; i < 4; i++) chk("t4_untouched", 32'(mem[500 + i]), 32'(501 + i));
    chk("t4_done_cnt", 32'(done_cnt), 1);
    mem_check("t4_memall");

    // Reset at the fourth edge after acceptance aborts the copy
    start_copy(0, 300, 8);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_addr_b", 32'(addr_b), 0);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("t5_written", 32'(mem[300 + i]), 32'(i + 1));
    for (int i = 3; i < 8; i++) chk("t5_kept", 32'(mem[300 + i]), 32'(301 + i));
    chk("t5_done_cnt", 32'(done_cnt), 0);
    mem_check("t5_memall");

    // In-place copy
    start_copy(0, 0, 8);
    wait_done(40);
    for (int i = 0; i < 8; i++) chk("t6_mem", 32'(mem[i]), 32'(i + 1));
    chk("t6_done_t", 32'(done_t), 9);
    mem_check("t6_memall");

    // Oversized length saturates to the full address space
    start_copy(5, 5, 1500);
    wait_done(1200);
    chk("t7_done_t", 32'(done_t), 1025);
    chk("t7_busy_cycles", 32'(busy_cnt), 1025);
    chk("t7_writes", 32'(web_cnt), 1024);
    mem_check("t7_memall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
